// File: rtl/meta_array_if.sv
// meta_array_if: requester-side write/lookup/flush handshake bundle for meta_array_ctrl
interface meta_array_if #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
);
  logic               wr_a_req;
  logic [S_INDEX-1:0] wr_a_addr;
  logic [WIDTH-1:0]   wr_a_data;
  logic               wr_a_gnt;
  logic               wr_b_req;
  logic [S_INDEX-1:0] wr_b_addr;
  logic [WIDTH-1:0]   wr_b_data;
  logic               wr_b_gnt;
  logic               rd_req;
  logic [S_INDEX-1:0] rd_addr;
  logic               rd_gnt;
  logic               rd_valid;
  logic [WIDTH-1:0]   rd_data;
  logic               flush_req;
  logic               flush_busy;
  logic               flush_done;
  modport master (
    output wr_a_req, wr_a_addr, wr_a_data, wr_b_req, wr_b_addr, wr_b_data,
           rd_req, rd_addr, flush_req,
    input  wr_a_gnt, wr_b_gnt, rd_gnt, rd_valid, rd_data, flush_busy, flush_done
  );
  modport slave (
    input  wr_a_req, wr_a_addr, wr_a_data, wr_b_req, wr_b_addr, wr_b_data,
           rd_req, rd_addr, flush_req,
    output wr_a_gnt, wr_b_gnt, rd_gnt, rd_valid, rd_data, flush_busy, flush_done
  );
endinterface

// File: rtl/meta_array_ctrl.sv
// meta_array_ctrl: round-robin write arbiter, flush sweeper and bypassed lookup port for a metadata FF array
module meta_array_ctrl #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
) (
  input  logic               clk,
  input  logic               rst,
  meta_array_if.slave        bus,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  output logic [WIDTH-1:0]   arr_din0,
  output logic               arr_csb1,
  output logic [S_INDEX-1:0] arr_addr1,
  input  logic [WIDTH-1:0]   arr_dout1
);
  localparam int NUM_SETS = 2**S_INDEX;
  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  state_t             state;
  logic               pri;
  logic [S_INDEX-1:0] cnt;
  logic               byp;
  logic [WIDTH-1:0]   byp_data;
  logic               rv, busy, done;
  logic               open, flushing, ga, gb, rg, wr_en;
  // grants are combinational; port 0 is rewritten every cycle so the array's latched web0 never goes stale
  always_comb begin
    open      = !rst && state == IDLE && !bus.flush_req;
    flushing  = !rst && state == FLUSH;
    ga        = open && bus.wr_a_req && (!bus.wr_b_req || !pri);
    gb        = open && bus.wr_b_req && (!bus.wr_a_req || pri);
    rg        = open && bus.rd_req;
    wr_en     = ga || gb || flushing;
    arr_csb0  = rst;
    arr_web0  = !wr_en;
    arr_addr0 = flushing ? cnt : gb ? bus.wr_b_addr : bus.wr_a_addr;
    arr_din0  = flushing ? '0 : gb ? bus.wr_b_data : bus.wr_a_data;
    arr_csb1  = !rg;
    arr_addr1 = bus.rd_addr;
    bus.wr_a_gnt   = ga;
    bus.wr_b_gnt   = gb;
    bus.rd_gnt     = rg;
    bus.rd_valid   = rv;
    bus.rd_data    = byp ? byp_data : arr_dout1;
    bus.flush_busy = busy;
    bus.flush_done = done;
  end
  // sweep FSM, fairness pointer and same-set write-to-read bypass capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pri      <= 1'b0;
      byp      <= 1'b0;
      byp_data <= '0;
      rv       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rv       <= rg;
      byp      <= rg && wr_en && arr_addr0 == bus.rd_addr;
      byp_data <= arr_din0;
      if (ga || gb) pri <= ga;
      case (state)
        IDLE: if (bus.flush_req) begin
          state <= FLUSH;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == S_INDEX'(NUM_SETS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_meta_array_ctrl.sv
// tb_meta_array_ctrl: self-checking bench with an array model and a set-level reference of the metadata contents
module tb_meta_array_ctrl;
  localparam int NS = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arr_csb0, arr_web0, arr_csb1;
  logic [3:0] arr_addr0, arr_addr1;
  logic       arr_din0, arr_dout1;
  logic       mem [NS];
  logic       ref_mem [NS];
  logic       b_turn, exp_rv, exp_rd;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  meta_array_if #(.S_INDEX(4), .WIDTH(1)) bus();
  meta_array_ctrl #(.S_INDEX(4), .WIDTH(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .arr_csb0(arr_csb0), .arr_web0(arr_web0), .arr_addr0(arr_addr0), .arr_din0(arr_din0),
    .arr_csb1(arr_csb1), .arr_addr1(arr_addr1), .arr_dout1(arr_dout1)
  );
  // two-port FF array: both ports registered, a same-edge read returns the pre-write contents
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) mem[i] <= 1'b0;
    end else begin
      if (!arr_csb1) arr_dout1 <= mem[arr_addr1];
      if (!arr_csb0 && !arr_web0) mem[arr_addr0] <= arr_din0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NS; i++) ref_mem[i] = 1'b0;
    b_turn = 1'b0;
    exp_rv = 1'b0;
    exp_rd = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.flush_req = 1'b0;
    bus.wr_a_req = 1'b1; bus.wr_a_addr = 4'd1; bus.wr_a_data = 1'b1;
    bus.wr_b_req = 1'b1; bus.wr_b_addr = 4'd2; bus.wr_b_data = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {bus.wr_a_gnt, bus.wr_b_gnt, bus.rd_gnt}, 0);
    chk("rst_rv", bus.rd_valid, 0);
    chk("rst_busy", bus.flush_busy, 0);
    chk("rst_done", bus.flush_done, 0);
    chk("rst_cs", {arr_csb0, arr_csb1, arr_web0}, 3'b111);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_a_req = 1'b0; bus.wr_b_req = 1'b0; bus.rd_req = 1'b0;
    model_reset();
  endtask
  // one IDLE cycle: drive, check grants and port drive against the set-level model, then retire the write
  task automatic idle_cycle(input logic a, input logic [3:0] aa, input logic ad,
                            input logic b, input logic [3:0] ba, input logic bd,
                            input logic r, input logic [3:0] ra);
    logic ga, gb;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    bus.wr_a_req = a; bus.wr_a_addr = aa; bus.wr_a_data = ad;
    bus.wr_b_req = b; bus.wr_b_addr = ba; bus.wr_b_data = bd;
    bus.rd_req = r; bus.rd_addr = ra;
    #1;
    chk("rd_valid", bus.rd_valid, exp_rv);
    if (exp_rv) chk("rd_data", bus.rd_data, exp_rd);
    ga = a && (!b || !b_turn);
    gb = b && !ga;
    chk("gnt_a", bus.wr_a_gnt, ga);
    chk("gnt_b", bus.wr_b_gnt, gb);
    chk("rd_gnt", bus.rd_gnt, r);
    chk("csb0", arr_csb0, 0);
    chk("web0", arr_web0, !(ga || gb));
    chk("csb1", arr_csb1, !r);
    if (r) chk("addr1", arr_addr1, ra);
    if (ga) chk("wr_a_port", {arr_addr0, arr_din0}, {aa, ad});
    if (gb) chk("wr_b_port", {arr_addr0, arr_din0}, {ba, bd});
    if (ga) ref_mem[aa] = ad;
    if (gb) ref_mem[ba] = bd;
    if (ga || gb) b_turn = ga;
    exp_rv = r;
    exp_rd = ref_mem[ra];
  endtask
  // flush request in cycle 0 with competing requests, then n sweep cycles checked
  task automatic flush_seq(input int n);
    @(posedge clk); #1;
    bus.flush_req = 1'b1;
    bus.wr_a_req = 1'b1; bus.wr_b_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 4'd0;
    #1;
    chk("f0_rv", bus.rd_valid, exp_rv);
    if (exp_rv) chk("f0_rd", bus.rd_data, exp_rd);
    chk("f0_gnt", {bus.wr_a_gnt, bus.wr_b_gnt, bus.rd_gnt}, 0);
    chk("f0_busy", bus.flush_busy, 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus.flush_req = (k < 3);
      #1;
      chk("f_busy", bus.flush_busy, 1);
      chk("f_done", bus.flush_done, k == NS + 1);
      chk("f_gnt", {bus.wr_a_gnt, bus.wr_b_gnt, bus.rd_gnt}, 0);
      if (k <= NS) chk("f_port", {arr_web0, arr_addr0, arr_din0}, {1'b0, 4'(k - 1), 1'b0});
      else chk("f_web", arr_web0, 1);
    end
    bus.flush_req = 1'b0;
    for (int i = 0; i < NS; i++) ref_mem[i] = 1'b0;
    exp_rv = 1'b0;
  endtask
  typedef struct {
    logic [2:0] req;
    logic [3:0] aa, ba, ra;
    logic [1:0] dat;
    logic [1:0] eg;
  } vec_t;
  vec_t v [12];
  initial begin
    v = '{
      '{3'b110, 4'h1, 4'h2, 4'h0, 2'b11, 2'b10},
      '{3'b111, 4'h3, 4'h4, 4'h1, 2'b11, 2'b01},
      '{3'b110, 4'h5, 4'h6, 4'h0, 2'b10, 2'b10},
      '{3'b111, 4'h7, 4'h8, 4'h4, 2'b01, 2'b01},
      '{3'b110, 4'h9, 4'hA, 4'h0, 2'b11, 2'b10},
      '{3'b111, 4'hB, 4'hC, 4'hC, 2'b00, 2'b01},
      '{3'b010, 4'h0, 4'hD, 4'h0, 2'b01, 2'b01},
      '{3'b111, 4'hE, 4'h0, 4'hE, 2'b10, 2'b10},
      '{3'b100, 4'hF, 4'h0, 4'h0, 2'b10, 2'b10},
      '{3'b111, 4'h1, 4'h1, 4'h1, 2'b01, 2'b01},
      '{3'b001, 4'h2, 4'h2, 4'hF, 2'b00, 2'b00},
      '{3'b110, 4'h3, 4'h4, 4'h0, 2'b00, 2'b10}
    };
    do_reset();
    idle_cycle(1, 4'd3, 1, 0, 0, 0, 0, 0);
    idle_cycle(0, 0, 0, 0, 0, 0, 1, 4'd3);
    idle_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_then_rd", {bus.rd_valid, bus.rd_data}, 2'b11);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle_cycle(v[i].req[2], v[i].aa, v[i].dat[1], v[i].req[1], v[i].ba, v[i].dat[0], v[i].req[0], v[i].ra);
      chk("tbl_gnt", {bus.wr_a_gnt, bus.wr_b_gnt}, v[i].eg);
    end
    do_reset();
    idle_cycle(0, 0, 0, 1, 4'd6, 1, 0, 0);
    idle_cycle(0, 0, 0, 1, 4'd5, 1, 1, 4'd5);
    idle_cycle(0, 0, 0, 1, 4'd5, 0, 1, 4'd6);
    chk("bypass_hit", bus.rd_data, 1);
    idle_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("bypass_miss", bus.rd_data, 1);
    idle_cycle(1, 4'd2, 1, 0, 0, 0, 0, 0);
    repeat (3) begin
      idle_cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle_web0", arr_web0, 1);
    end
    idle_cycle(1, 4'd4, 0, 0, 0, 0, 0, 0);
    idle_cycle(0, 0, 0, 0, 0, 0, 1, 4'd2);
    idle_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("set2_kept", bus.rd_data, 1);
    for (int i = 0; i < NS; i++) idle_cycle(i[0], 4'(i), 1, !i[0], 4'(i), 1, 0, 0);
    flush_seq(NS + 1);
    idle_cycle(1, 4'd9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NS; i++) idle_cycle(0, 0, 0, 0, 0, 0, 1, 4'(i));
    for (int i = 0; i < NS; i++) idle_cycle(1, 4'(i), 1, 0, 0, 0, 0, 0);
    flush_seq(4);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wr_a_req = 1'b0; bus.rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.flush_busy, 0);
    chk("abort_done", bus.flush_done, 0);
    model_reset();
    for (int i = 0; i < NS + 2; i++) begin
      idle_cycle(0, 0, 0, 0, 0, 0, 1, 4'(i));
      chk("abort_no_done", {bus.flush_busy, bus.flush_done}, 0);
    end
    for (int i = 0; i < 400; i++)
      idle_cycle(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 4'($urandom));
    idle_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/meta_array_ctrl.md
# meta_array_ctrl

Sequencer and arbiter for one cache metadata flip-flop array (the `S_INDEX`/`WIDTH` two-port array: registered port 0 read/write, registered port 1 read). It shares the single write port between two write requesters with round-robin fairness. It runs a set-by-set flush sweep and issues lookups on port 1. Lookups always return coherent data: a same-cycle write to the same set is forwarded to the read.

## Interface
- `S_INDEX`, default 4: set index width; `NUM_SETS = 2**S_INDEX`.
- `WIDTH`, default 1: metadata entry width.
- `clk` in 1: single clock; drives the array's `clk0` and `clk1`.
- `rst` in 1: synchronous, active-high reset; also drives the array's `rst0` and `rst1`.
- `wr_a_req` in 1: requester A wants a write this cycle.
- `wr_a_addr` in S_INDEX: set index for A.
- `wr_a_data` in WIDTH: data for A.
- `wr_a_gnt` out 1: A's write was issued this cycle.
- `wr_b_req` in 1: requester B wants a write this cycle.
- `wr_b_addr` in S_INDEX: set index for B.
- `wr_b_data` in WIDTH: data for B.
- `wr_b_gnt` out 1: B's write was issued this cycle.
- `rd_req` in 1: lookup request.
- `rd_addr` in S_INDEX: lookup set index.
- `rd_gnt` out 1: lookup accepted this cycle.
- `rd_valid` out 1: `rd_data` is valid; asserted the cycle after `rd_gnt`.
- `rd_data` out WIDTH: lookup result.
- `flush_req` in 1: start a zeroing sweep of all sets.
- `flush_busy` out 1: a sweep is in progress.
- `flush_done` out 1: one-cycle pulse when the sweep completes.
- `arr_csb0`, `arr_web0` out 1 each: array port 0 chip-select and write-enable, both active-low.
- `arr_addr0` out S_INDEX: array port 0 address.
- `arr_din0` out WIDTH: array port 0 write data.
- `arr_csb1` out 1: array port 1 chip-select, active-low.
- `arr_addr1` out S_INDEX: array port 1 address.
- `arr_dout1` in WIDTH: array port 1 read data.

## Operation
- FSM states: IDLE, FLUSH, DONE. Reset state is IDLE.
- IDLE with `flush_req`=1:
  - no write or read grants that cycle;
  - flush counter cleared to 0;
  - next state is FLUSH.
- IDLE with `flush_req`=0: arbitrate the writes and grant the read, as below.
- FLUSH:
  - each cycle writes 0 to set `cnt`, then `cnt` increments;
  - after writing set `NUM_SETS-1`, next state is DONE;
  - all grants are 0;
  - `flush_req` is ignored.
- DONE: `flush_done`=1 and all grants 0; next state is IDLE.
- Write arbitration (IDLE only):
  - priority pointer `pri`; reset value is A.
  - Only one side requesting: that side is granted.
  - Both requesting: the `pri` side is granted.
  - After any grant, `pri` points to the side that was not granted.
  - At most one grant per cycle.
- Port 0 drive:
  - `arr_csb0`=0 every non-reset cycle.
  - `arr_web0`=0 only on a granted write or a flush write; otherwise `arr_web0`=1. This clears the array's latched write-enable so no stale write repeats.
  - `arr_addr0`/`arr_din0` carry the granted side's address/data, or `cnt`/0 during a flush.
- Read:
  - `rd_gnt` = `rd_req` && state==IDLE && !`flush_req`.
  - On `rd_gnt`: `arr_csb1`=0 and `arr_addr1`=`rd_addr`; otherwise `arr_csb1`=1.
- Forwarding:
  - A read granted in the same cycle as a write to the same set would see pre-write data.
  - The controller registers a bypass flag and the write data.
  - On the next cycle, `rd_data` = the bypass data if the flag is set, else `arr_dout1`.
  - A read one or more cycles after a write needs no bypass.
- Reset values:
  - `wr_a_gnt`=`wr_b_gnt`=`rd_gnt`=`rd_valid`=`flush_busy`=`flush_done`=0;
  - `arr_csb0`=`arr_csb1`=`arr_web0`=1;
  - `pri`=A, `cnt`=0, bypass flag 0.
- Reset mid-flush: the sweep aborts and the FSM returns to IDLE with no `flush_done`. The array contents are zeroed by the shared reset.

## Timing
- Write granted at cycle N: visible to a read granted at cycle N via bypass, and to a read granted at N+1 or later directly.
- Read latency: `rd_valid`/`rd_data` at N+1 for `rd_gnt` at N. Back-to-back reads give one result per cycle.
- Flush with `flush_req` at cycle 0:
  - sets 0..NUM_SETS-1 are written in cycles 1..NUM_SETS;
  - `flush_busy`=1 in cycles 1..NUM_SETS+1;
  - `flush_done`=1 in cycle NUM_SETS+1;
  - grants resume in cycle NUM_SETS+2.
- Grants are combinational from requests and state: same cycle, zero latency.

## Test plan
- Reset, then A writes set 3 with data 1; read set 3 at N+1 -> `rd_valid` at N+2 with `rd_data`=1.
- A and B request every cycle for 6 cycles -> grants alternate A,B,A,B,A,B; at most one grant per cycle.
- Same cycle: B writes set 5 with data 1 and a read of set 5 -> `rd_data`=1 at N+1 (bypass). With the read on set 6 instead -> the old value of set 6.
- Write all 16 sets with 1, pulse `flush_req` at cycle 0 with A requesting -> no grants in cycles 0..17, `flush_done` at cycle 17, then reads of every set return 0.
- Assert `rst` at cycle 5 of a flush -> state IDLE, `flush_busy`=0, no `flush_done`, all sets read 0.
- Write set 2 once, then 3 idle cycles -> `arr_web0`=1 in each idle cycle, and set 2 keeps its value after a later write to set 4.
